// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Brief    : Shared constants and in-flight tracking entry for hazard_ctrl
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic            vld;
        logic [RA_W-1:0] rd;
        logic            wr;
        logic            load;
    } trk_entry_t;

    // x0 is hard-wired zero, so it never produces a forwarding hit.
    function automatic logic ent_match(input trk_entry_t e, input logic [RA_W-1:0] a);
        return e.vld & e.wr & (e.rd == a) & (a != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
//  Module   : hazard_fwd_sel
//  Brief    : Per-operand table match, youngest-first forward select, hazard
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_sel #(
    parameter int XLEN     = hazard_ctrl_pkg::XLEN,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 1
) (
    input  hazard_ctrl_pkg::trk_entry_t [NSTG-1:0] i_tbl,
    input  logic [NSTG*XLEN-1:0]                   i_res_data,
    input  logic [XLEN-1:0]                        i_rf_rd,
    input  logic [hazard_ctrl_pkg::RA_W-1:0]       i_addr,
    input  logic                                   i_use,
    input  logic                                   i_os_vld,
    output logic [XLEN-1:0]                        o_opnd,
    output logic                                   o_hazard
);
    import hazard_ctrl_pkg::*;

    logic [XLEN-1:0] w_opnd;
    logic            w_hit;
    logic            w_rdy;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_opnd = i_rf_rd;
        w_hit  = 1'b0;
        w_rdy  = 1'b1;
        for (int k = NSTG - 1; k >= 0; k--) begin
            if (ent_match(i_tbl[k], i_addr)) begin
                w_opnd = i_res_data[k*XLEN +: XLEN];
                w_hit  = 1'b1;
                w_rdy  = !(i_tbl[k].load && (k < LOAD_LAT));
            end
        end
        if (i_addr == '0) begin
            w_opnd = '0;
        end
    end

    assign o_opnd   = w_opnd;
    assign o_hazard = i_os_vld & i_use & w_hit & ~w_rdy;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline hazard control: forwarding, load-use stall, jump flush
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int XLEN        = hazard_ctrl_pkg::XLEN,
    parameter int NSTG        = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_os_vld,
    input  logic [hazard_ctrl_pkg::RA_W-1:0]   i_os_rs1,
    input  logic [hazard_ctrl_pkg::RA_W-1:0]   i_os_rs2,
    input  logic                               i_os_use1,
    input  logic                               i_os_use2,
    input  logic [hazard_ctrl_pkg::RA_W-1:0]   i_os_rd,
    input  logic                               i_os_wr,
    input  logic                               i_os_load,
    input  logic [XLEN-1:0]                    i_rf_rd1,
    input  logic [XLEN-1:0]                    i_rf_rd2,
    input  logic [NSTG*XLEN-1:0]               i_res_data,
    input  logic                               i_ex_jmp_vld,
    input  logic [XLEN-1:0]                    i_ex_jmp_addr,
    output logic [XLEN-1:0]                    o_of_x1,
    output logic [XLEN-1:0]                    o_of_x2,
    output logic                               o_stall,
    output logic                               o_nop,
    output logic                               o_jmp_vld,
    output logic [XLEN-1:0]                    o_jmp_addr,
    output logic                               o_ex_vld,
    output logic [CNT_W-1:0]                   o_cnt_stall,
    output logic [CNT_W-1:0]                   o_cnt_flush
);
    import hazard_ctrl_pkg::*;

    trk_entry_t [NSTG-1:0] r_tbl;
    logic [2:0]            r_fl_cnt;
    logic [CNT_W-1:0]      r_cnt_stall;
    logic [CNT_W-1:0]      r_cnt_flush;

    logic       w_haz1;
    logic       w_haz2;
    logic       w_taken;
    logic       w_nop;
    logic       w_stall;
    logic       w_issue;
    trk_entry_t w_new;

    hazard_fwd_sel #(
        .XLEN     (XLEN),
        .NSTG     (NSTG),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd1 (
        .i_tbl      (r_tbl),
        .i_res_data (i_res_data),
        .i_rf_rd    (i_rf_rd1),
        .i_addr     (i_os_rs1),
        .i_use      (i_os_use1),
        .i_os_vld   (i_os_vld),
        .o_opnd     (o_of_x1),
        .o_hazard   (w_haz1)
    );

    hazard_fwd_sel #(
        .XLEN     (XLEN),
        .NSTG     (NSTG),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd2 (
        .i_tbl      (r_tbl),
        .i_res_data (i_res_data),
        .i_rf_rd    (i_rf_rd2),
        .i_addr     (i_os_rs2),
        .i_use      (i_os_use2),
        .i_os_vld   (i_os_vld),
        .o_opnd     (o_of_x2),
        .o_hazard   (w_haz2)
    );

    // A jump only counts when the instruction sitting in EX is real.
    assign w_taken = i_ex_jmp_vld & r_tbl[0].vld;
    assign w_nop   = w_taken | (r_fl_cnt != 3'd0);
    assign w_stall = (w_haz1 | w_haz2) & ~w_nop;
    assign w_issue = i_os_vld & ~w_stall & ~w_nop;
    assign w_new   = w_issue ? trk_entry_t'{vld: 1'b1, rd: i_os_rd, wr: i_os_wr, load: i_os_load}
                             : trk_entry_t'('0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl       <= '0;
            r_fl_cnt    <= 3'd0;
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
        end else begin
            r_tbl <= {r_tbl[NSTG-2:0], w_new};

            if (w_taken) begin
                r_fl_cnt <= 3'(FLUSH_DEPTH - 1);
            end else if (r_fl_cnt != 3'd0) begin
                r_fl_cnt <= r_fl_cnt - 3'd1;
            end

            if (w_stall && (r_cnt_stall != '1)) begin
                r_cnt_stall <= r_cnt_stall + 1'b1;
            end
            if (w_taken && (r_cnt_flush != '1)) begin
                r_cnt_flush <= r_cnt_flush + 1'b1;
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_nop       = w_nop;
    assign o_jmp_vld   = w_taken;
    assign o_jmp_addr  = i_ex_jmp_addr;
    assign o_ex_vld    = r_tbl[0].vld;
    assign o_cnt_stall = r_cnt_stall;
    assign o_cnt_flush = r_cnt_flush;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Directed scoreboard bench for hazard_ctrl (default parameters)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int XLEN = 32;
    localparam int NSTG = 3;
    localparam int CNT_W = 16;

    localparam logic [31:0] R0  = 32'h1111_0000;
    localparam logic [31:0] R1  = 32'h2222_0000;
    localparam logic [31:0] R2  = 32'h3333_0000;
    localparam logic [31:0] RF1 = 32'hAAAA_0001;
    localparam logic [31:0] RF2 = 32'hBBBB_0002;

    localparam logic [8:0] M_X1 = 9'h001;
    localparam logic [8:0] M_X2 = 9'h002;
    localparam logic [8:0] M_ST = 9'h004;
    localparam logic [8:0] M_NP = 9'h008;
    localparam logic [8:0] M_JV = 9'h010;
    localparam logic [8:0] M_JA = 9'h020;
    localparam logic [8:0] M_EV = 9'h040;
    localparam logic [8:0] M_CS = 9'h080;
    localparam logic [8:0] M_CF = 9'h100;

    typedef struct packed {
        int          id;
        logic [8:0]  mask;
        logic [31:0] x1;
        logic [31:0] x2;
        logic        st;
        logic        np;
        logic        jv;
        logic [31:0] ja;
        logic        ev;
        logic [15:0] cs;
        logic [15:0] cf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 os_vld, os_use1, os_use2, os_wr, os_load;
    logic [4:0]           os_rs1, os_rs2, os_rd;
    logic [XLEN-1:0]      rf_rd1, rf_rd2;
    logic [NSTG*XLEN-1:0] res_data;
    logic                 ex_jmp_vld;
    logic [XLEN-1:0]      ex_jmp_addr;
    logic [XLEN-1:0]      of_x1, of_x2, jmp_addr;
    logic                 stall, nop, jmp_vld, ex_vld;
    logic [CNT_W-1:0]     cnt_stall, cnt_flush;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_os_vld      (os_vld),
        .i_os_rs1      (os_rs1),
        .i_os_rs2      (os_rs2),
        .i_os_use1     (os_use1),
        .i_os_use2     (os_use2),
        .i_os_rd       (os_rd),
        .i_os_wr       (os_wr),
        .i_os_load     (os_load),
        .i_rf_rd1      (rf_rd1),
        .i_rf_rd2      (rf_rd2),
        .i_res_data    (res_data),
        .i_ex_jmp_vld  (ex_jmp_vld),
        .i_ex_jmp_addr (ex_jmp_addr),
        .o_of_x1       (of_x1),
        .o_of_x2       (of_x2),
        .o_stall       (stall),
        .o_nop         (nop),
        .o_jmp_vld     (jmp_vld),
        .o_jmp_addr    (jmp_addr),
        .o_ex_vld      (ex_vld),
        .o_cnt_stall   (cnt_stall),
        .o_cnt_flush   (cnt_flush)
    );

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Monitor: outputs are combinational per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.mask[0]) cmp("of_x1",     e.id, of_x1,            e.x1);
            if (e.mask[1]) cmp("of_x2",     e.id, of_x2,            e.x2);
            if (e.mask[2]) cmp("stall",     e.id, 32'(stall),       32'(e.st));
            if (e.mask[3]) cmp("nop",       e.id, 32'(nop),         32'(e.np));
            if (e.mask[4]) cmp("jmp_vld",   e.id, 32'(jmp_vld),     32'(e.jv));
            if (e.mask[5]) cmp("jmp_addr",  e.id, jmp_addr,         e.ja);
            if (e.mask[6]) cmp("ex_vld",    e.id, 32'(ex_vld),      32'(e.ev));
            if (e.mask[7]) cmp("cnt_stall", e.id, 32'(cnt_stall),   32'(e.cs));
            if (e.mask[8]) cmp("cnt_flush", e.id, 32'(cnt_flush),   32'(e.cf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic os(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld);
        os_vld  = v;
        os_rs1  = r1;
        os_use1 = u1;
        os_rs2  = r2;
        os_use2 = u2;
        os_rd   = rd;
        os_wr   = wr;
        os_load = ld;
    endtask

    task automatic jmp(input logic v, input logic [31:0] a);
        ex_jmp_vld  = v;
        ex_jmp_addr = a;
    endtask

    task automatic chk(input int id, input logic [8:0] m,
                       input logic [31:0] x1, input logic [31:0] x2,
                       input logic st, input logic np, input logic jv,
                       input logic [31:0] ja, input logic ev,
                       input logic [15:0] cs, input logic [15:0] cf);
        exp_t e;
        e = '{id: id, mask: m, x1: x1, x2: x2, st: st, np: np, jv: jv,
              ja: ja, ev: ev, cs: cs, cf: cf};
        sb_q.push_back(e);
    endtask

    initial begin
        rst_n    = 1'b0;
        rf_rd1   = RF1;
        rf_rd2   = RF2;
        res_data = {R2, R1, R0};
        os(0, 0, 0, 0, 0, 0, 0, 0);
        jmp(0, 0);
        tick();

        // Reset: jump request ignored, everything idle
        jmp(1, 32'h40);
        chk(0, M_ST|M_NP|M_JV|M_EV|M_CS|M_CF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        jmp(0, 0);

        // addi x5 issue, then consumer of x5 forwarded from stage 0
        os(1, 1, 1, 2, 1, 5, 1, 0);  chk(1, M_X1|M_X2|M_ST|M_EV, RF1, RF2, 0, 0, 0, 0, 0, 0, 0); tick();
        os(1, 5, 1, 0, 1, 8, 1, 0);  chk(2, M_X1|M_X2|M_ST|M_EV, R0, 0, 0, 0, 0, 0, 1, 0, 0);    tick();
        // lw x6 issue; x5 now in stage 1, x8 in stage 0
        os(1, 5, 1, 8, 1, 6, 1, 1);  chk(3, M_X1|M_X2|M_ST, R1, R0, 0, 0, 0, 0, 0, 0, 0);        tick();
        // load-use: one stall cycle, then load data from stage 1
        os(1, 6, 1, 0, 0, 9, 1, 0);  chk(4, M_X1|M_ST|M_NP|M_CS, R0, 0, 1, 0, 0, 0, 0, 0, 0);    tick();
        chk(5, M_X1|M_ST|M_EV|M_CS, R1, 0, 0, 0, 0, 0, 0, 16'd1, 0);                              tick();
        // x0 reads return zero even when an x0 writer is in flight
        os(1, 0, 1, 6, 1, 0, 1, 0);  chk(6, M_X1|M_X2|M_ST, 0, R2, 0, 0, 0, 0, 0, 0, 0);          tick();
        os(1, 0, 1, 9, 1, 7, 1, 0);  chk(7, M_X1|M_X2|M_ST|M_EV, 0, R1, 0, 0, 0, 0, 1, 0, 0);    tick();
        // x7 written twice: youngest writer wins, then drains to register file
        os(1, 7, 1, 0, 0, 11, 1, 0); chk(8, M_X1, R0, 0, 0, 0, 0, 0, 0, 0, 0);                    tick();
        os(1, 7, 1, 0, 0, 7, 1, 0);  chk(9, M_X1, R1, 0, 0, 0, 0, 0, 0, 0, 0);                    tick();
        os(0, 7, 1, 0, 0, 0, 0, 0);  chk(10, M_X1|M_ST, R0, 0, 0, 0, 0, 0, 0, 0, 0);              tick();
        chk(11, M_X1, R1, 0, 0, 0, 0, 0, 0, 0, 0);                                                tick();
        chk(12, M_X1, R2, 0, 0, 0, 0, 0, 0, 0, 0);                                                tick();
        // Empty pipe: forward from register file, jump with invalid EX ignored
        jmp(1, 32'h80);
        chk(13, M_X1|M_NP|M_JV|M_EV, RF1, 0, 0, 0, 0, 0, 0, 0, 0);                               tick();
        jmp(0, 0);

        // Jump beats a simultaneous load-use stall
        os(1, 1, 0, 2, 0, 12, 1, 1); chk(14, M_ST|M_NP, 0, 0, 0, 0, 0, 0, 0, 0, 0);               tick();
        os(1, 12, 1, 0, 0, 13, 1, 0);
        jmp(1, 32'h100);
        chk(15, M_ST|M_NP|M_JV|M_JA|M_EV|M_CS|M_CF, 0, 0, 0, 1, 1, 32'h100, 1, 16'd1, 0);        tick();
        jmp(0, 0);
        chk(16, M_X1|M_ST|M_NP|M_JV|M_EV|M_CF, R1, 0, 0, 1, 0, 0, 0, 0, 16'd1);                 tick();
        os(1, 12, 1, 0, 0, 14, 1, 0);
        chk(17, M_X1|M_ST|M_NP|M_CS|M_CF, R2, 0, 0, 0, 0, 0, 0, 16'd1, 16'd1);                   tick();

        // Reset asserted inside a flush window
        os(0, 0, 0, 0, 0, 0, 0, 0);
        jmp(1, 32'h200);
        chk(18, M_NP|M_JV|M_JA|M_EV|M_CF, 0, 0, 0, 1, 1, 32'h200, 1, 0, 16'd1);                  tick();
        jmp(0, 0);
        rst_n = 1'b0;
        chk(19, M_ST|M_NP|M_JV|M_EV|M_CS|M_CF, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       tick();
        rst_n = 1'b1;
        os(1, 14, 1, 0, 0, 15, 1, 0);
        chk(20, M_X1|M_ST|M_NP|M_EV|M_CS|M_CF, RF1, 0, 0, 0, 0, 0, 0, 0, 0);                     tick();
        os(0, 15, 1, 0, 0, 0, 0, 0);
        chk(21, M_X1|M_EV, R0, 0, 0, 0, 0, 0, 1, 0, 0);                                          tick();

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
